// File: rtl/es_ordered_mul_ext.sv
// es_ordered_mul_ext: ordered deterministic-stochastic multiplier core.
// Latches NUM_INPUTS operands, walks the ordered unary stream positions one
// per enabled cycle and counts AND hits (exact product) or OR hits. In AND
// mode with EARLY_TERM set, stream blocks that cannot produce a hit are skipped.
module es_ordered_mul_ext #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter bit EARLY_TERM = 1'b1,
  localparam int OUT_WIDTH = DATA_WIDTH*NUM_INPUTS+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS],
  output logic [OUT_WIDTH-1:0]  bin_data_out,
  output logic [OUT_WIDTH-1:0]  cycles_out,
  output logic                  busy,
  output logic                  done
);

  localparam int TW = DATA_WIDTH*NUM_INPUTS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [TW-1:0]         t_q;
  logic [DATA_WIDTH-1:0] x_q [NUM_INPUTS];
  logic                  mode_q;
  logic [OUT_WIDTH-1:0]  acc_q;
  logic [OUT_WIDTH-1:0]  cnt_q;

  logic                  hit_and;
  logic                  hit_or;
  logic                  hit;
  int                    skip_k;
  logic [TW:0]           one_ext;
  logic [TW:0]           step_inc;
  logic [TW:0]           t_adv;
  logic [OUT_WIDTH-1:0]  acc_nxt;
  logic [OUT_WIDTH-1:0]  cnt_nxt;
  logic                  any_zero_in;

  // Evaluate the current stream position and compute the next position.
  // The highest digit with d_k >= x_k dominates: every position below it in
  // that block misses in AND mode, so the step clears lower digits and bumps
  // d_k. With no such digit the step collapses to a plain +1. The extra top
  // bit of t_adv is the end-of-stream carry.
  always_comb begin
    hit_and = 1'b1;
    hit_or  = 1'b0;
    skip_k  = 0;
    one_ext = {{TW{1'b0}}, 1'b1};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (t_q[i*DATA_WIDTH +: DATA_WIDTH] < x_q[i]) begin
        hit_or = 1'b1;
      end else begin
        hit_and = 1'b0;
        skip_k  = i;
      end
    end
    hit = mode_q ? hit_or : hit_and;
    if (!mode_q && EARLY_TERM) begin
      step_inc = one_ext << (skip_k*DATA_WIDTH);
    end else begin
      step_inc = one_ext;
    end
    t_adv   = ({1'b0, t_q} & ~(step_inc - one_ext)) + step_inc;
    acc_nxt = acc_q + OUT_WIDTH'(hit);
    cnt_nxt = cnt_q + OUT_WIDTH'(1);
  end

  // Detect a zero operand at start; an AND run with a zero operand has no hits.
  always_comb begin
    any_zero_in = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bin_data_in[i] == '0) any_zero_in = 1'b1;
    end
  end

  // Control FSM with accumulator, cycle counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      t_q          <= '0;
      x_q          <= '{default: '0};
      mode_q       <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      bin_data_out <= '0;
      cycles_out   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            x_q    <= bin_data_in;
            mode_q <= mode;
            t_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            if (!mode && EARLY_TERM && any_zero_in) begin
              state        <= S_DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              bin_data_out <= '0;
              cycles_out   <= '0;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_nxt;
          t_q   <= t_adv[TW-1:0];
          if (t_adv[TW]) begin
            state        <= S_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            bin_data_out <= acc_nxt;
            cycles_out   <= cnt_nxt;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_es_ordered_mul_ext.sv
// Testbench for es_ordered_mul_ext: three instances (W=2 full-length, W=2 with
// early termination, W=3 with early termination) checked against closed-form
// product/OR-count and visited-position formulas.
module tb_es_ordered_mul_ext;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       mode = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic [1:0] din2 [2];
  logic [2:0] din3 [2];

  logic [4:0] out_a, cyc_a, out_b, cyc_b;
  logic [6:0] out_c, cyc_c;
  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  es_ordered_mul_ext #(.DATA_WIDTH(2), .NUM_INPUTS(2), .EARLY_TERM(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .start(start_v[0]), .mode(mode),
    .bin_data_in(din2), .bin_data_out(out_a), .cycles_out(cyc_a),
    .busy(busy_a), .done(done_a));

  es_ordered_mul_ext #(.DATA_WIDTH(2), .NUM_INPUTS(2), .EARLY_TERM(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en), .start(start_v[1]), .mode(mode),
    .bin_data_in(din2), .bin_data_out(out_b), .cycles_out(cyc_b),
    .busy(busy_b), .done(done_b));

  es_ordered_mul_ext #(.DATA_WIDTH(3), .NUM_INPUTS(2), .EARLY_TERM(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .start(start_v[2]), .mode(mode),
    .bin_data_in(din3), .bin_data_out(out_c), .cycles_out(cyc_c),
    .busy(busy_c), .done(done_c));

  function automatic int get_out(input int which);
    case (which)
      0:       return int'(out_a);
      1:       return int'(out_b);
      default: return int'(out_c);
    endcase
  endfunction

  function automatic int get_cyc(input int which);
    case (which)
      0:       return int'(cyc_a);
      1:       return int'(cyc_b);
      default: return int'(cyc_c);
    endcase
  endfunction

  function automatic bit get_busy(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic bit get_done(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic int dut_w(input int which);
    return (which == 2) ? 3 : 2;
  endfunction

  function automatic bit dut_et(input int which);
    return (which != 0);
  endfunction

  // Reference result: AND counts prod(x_i), OR counts the complement of the
  // positions where every stream is 0.
  function automatic int m_result(input int w, input int x0, input int x1, input bit md);
    if (!md) return x0 * x1;
    return (1 << (2*w)) - ((1 << w) - x0) * ((1 << w) - x1);
  endfunction

  // Reference cycle count. With early skip, the low digit always takes 2^W
  // positions per block; in the top digit the x1 good values each hold a full
  // low block, and each of the remaining 2^W - x1 values costs one position.
  function automatic int m_cycles(input int w, input int x0, input int x1,
                                  input bit md, input bit et);
    if (md || !et) return 1 << (2*w);
    if (x0 == 0 || x1 == 0) return 0;
    return x1 * (1 << w) + ((1 << w) - x1);
  endfunction

  // Launch one operation and wait for done. With rnd set, en, mode, operands
  // and stray start pulses (only while busy) are randomised during the run.
  task automatic run_op(input int which, input int x0, input int x1, input bit md,
                        input bit rnd, output int o, output int c, output int lat,
                        output bit excl_bad, output bit tmo);
    excl_bad = 1'b0;
    @(negedge clk);
    if (which == 2) begin
      din3[0] = 3'(x0);
      din3[1] = 3'(x1);
    end else begin
      din2[0] = 2'(x0);
      din2[1] = 2'(x1);
    end
    mode = md;
    en = 1'b1;
    start_v[which] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[which] = 1'b0;
    lat = 0;
    while (!get_done(which) && lat < 5000) begin
      if (rnd) begin
        en = ($urandom_range(0, 9) < 7);
        mode = 1'($urandom);
        din2[0] = 2'($urandom);
        din2[1] = 2'($urandom);
        din3[0] = 3'($urandom);
        din3[1] = 3'($urandom);
        start_v[which] = get_busy(which) && ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      lat++;
      if (get_busy(which) && get_done(which)) excl_bad = 1'b1;
    end
    en = 1'b1;
    start_v[which] = 1'b0;
    tmo = !get_done(which);
    o = get_out(which);
    c = get_cyc(which);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      vectors++;
      if (get_out(w) !== 0) begin
        miscompares++;
        $display("FAIL reset_out dut%0d got %0d exp 0", w, get_out(w));
      end
      vectors++;
      if (get_cyc(w) !== 0) begin
        miscompares++;
        $display("FAIL reset_cycles dut%0d got %0d exp 0", w, get_cyc(w));
      end
      vectors++;
      if (get_busy(w) !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy dut%0d got %0b exp 0", w, get_busy(w));
      end
      vectors++;
      if (get_done(w) !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_done dut%0d got %0b exp 0", w, get_done(w));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    int dut_l [5] = '{0, 1, 1, 1, 0};
    int x0_l  [5] = '{3, 3, 3, 3, 3};
    int x1_l  [5] = '{2, 2, 2, 0, 0};
    bit md_l  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int eo_l  [5] = '{6, 6, 14, 0, 0};
    int ec_l  [5] = '{16, 10, 16, 0, 16};
    int o, c, lat;
    bit xb, tmo;
    for (int k = 0; k < 5; k++) begin
      run_op(dut_l[k], x0_l[k], x1_l[k], md_l[k], 1'b0, o, c, lat, xb, tmo);
      vectors++;
      if (tmo) begin
        miscompares++;
        $display("FAIL spec_timeout case%0d got done=0 exp done=1", k);
      end
      vectors++;
      if (o !== eo_l[k]) begin
        miscompares++;
        $display("FAIL spec_out case%0d got %0d exp %0d", k, o, eo_l[k]);
      end
      vectors++;
      if (c !== ec_l[k]) begin
        miscompares++;
        $display("FAIL spec_cycles case%0d got %0d exp %0d", k, c, ec_l[k]);
      end
      vectors++;
      if (lat !== ec_l[k]) begin
        miscompares++;
        $display("FAIL spec_latency case%0d got %0d exp %0d", k, lat, ec_l[k]);
      end
      vectors++;
      if (xb) begin
        miscompares++;
        $display("FAIL spec_busy_done_excl case%0d got both=1 exp exclusive", k);
      end
    end
    // done and the result hold with no further start
    repeat (3) @(negedge clk);
    vectors++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL done_hold got done=%0b busy=%0b exp done=1 busy=0", done_a, busy_a);
    end
    vectors++;
    if (cyc_a !== 5'd16) begin
      miscompares++;
      $display("FAIL done_hold_cycles got %0d exp 16", cyc_a);
    end
  endtask

  task automatic test_random_ops();
    int o, c, lat, which, x0, x1, eo, ec;
    bit md, xb, tmo;
    for (int k = 0; k < 24; k++) begin
      which = $urandom_range(0, 2);
      x0 = $urandom_range(0, (1 << dut_w(which)) - 1);
      x1 = $urandom_range(0, (1 << dut_w(which)) - 1);
      md = 1'($urandom);
      eo = m_result(dut_w(which), x0, x1, md);
      ec = m_cycles(dut_w(which), x0, x1, md, dut_et(which));
      run_op(which, x0, x1, md, 1'b0, o, c, lat, xb, tmo);
      vectors++;
      if (tmo || xb || o !== eo || c !== ec || lat !== ec) begin
        miscompares++;
        $display("FAIL random_op dut%0d x=(%0d,%0d) md=%0b got out=%0d cyc=%0d lat=%0d tmo=%0b excl=%0b exp out=%0d cyc=%0d",
                 which, x0, x1, md, o, c, lat, tmo, xb, eo, ec);
      end
    end
  endtask

  task automatic test_en_toggle();
    int o, c, lat, which, x0, x1, eo, ec;
    bit md, xb, tmo;
    for (int k = 0; k < 10; k++) begin
      which = (k % 2 == 0) ? 1 : 2;
      x0 = $urandom_range(1, (1 << dut_w(which)) - 1);
      x1 = $urandom_range(1, (1 << dut_w(which)) - 1);
      md = 1'($urandom);
      eo = m_result(dut_w(which), x0, x1, md);
      ec = m_cycles(dut_w(which), x0, x1, md, dut_et(which));
      run_op(which, x0, x1, md, 1'b1, o, c, lat, xb, tmo);
      vectors++;
      if (tmo || xb || o !== eo || c !== ec) begin
        miscompares++;
        $display("FAIL en_toggle dut%0d x=(%0d,%0d) md=%0b got out=%0d cyc=%0d tmo=%0b excl=%0b exp out=%0d cyc=%0d",
                 which, x0, x1, md, o, c, tmo, xb, eo, ec);
      end
    end
  endtask

  task automatic test_rst_mid_run();
    int o, c, lat;
    bit xb, tmo;
    @(negedge clk);
    din2[0] = 2'd3;
    din2[1] = 2'd2;
    mode = 1'b0;
    en = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy_b !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_busy got %0b exp 1", busy_b);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || out_b !== 5'd0 || cyc_b !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_mid_run got busy=%0b done=%0b out=%0d cyc=%0d exp all 0",
               busy_b, done_b, out_b, cyc_b);
    end
    run_op(1, 3, 2, 1'b0, 1'b0, o, c, lat, xb, tmo);
    vectors++;
    if (tmo || o !== 6 || c !== 10 || lat !== 10) begin
      miscompares++;
      $display("FAIL rst_restart got out=%0d cyc=%0d lat=%0d tmo=%0b exp out=6 cyc=10 lat=10",
               o, c, lat, tmo);
    end
  endtask

  task automatic test_sweep_w3();
    int o, c, lat, eo, ec;
    bit xb, tmo;
    for (int m = 0; m < 2; m++) begin
      for (int x0 = 0; x0 < 8; x0++) begin
        for (int x1 = 0; x1 < 8; x1++) begin
          eo = m_result(3, x0, x1, 1'(m));
          ec = m_cycles(3, x0, x1, 1'(m), 1'b1);
          run_op(2, x0, x1, 1'(m), 1'b0, o, c, lat, xb, tmo);
          vectors++;
          if (tmo || xb || o !== eo || c !== ec || lat !== ec) begin
            miscompares++;
            $display("FAIL sweep_w3 x=(%0d,%0d) md=%0d got out=%0d cyc=%0d lat=%0d tmo=%0b excl=%0b exp out=%0d cyc=%0d",
                     x0, x1, m, o, c, lat, tmo, xb, eo, ec);
          end
        end
      end
    end
  endtask

  initial begin
    din2[0] = '0;
    din2[1] = '0;
    din3[0] = '0;
    din3[1] = '0;
    test_reset();
    test_spec_vectors();
    test_random_ops();
    test_en_toggle();
    test_rst_mid_run();
    test_sweep_w3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
